// File: rtl/sobel_window_3x3_if.sv
// Pixel-in / window-out bundle between the CCD front end, the 3x3 window
// builder and the Sobel stage.
interface sobel_window_3x3_if #(
    parameter int DW = 10
);
    logic              in_valid;
    logic              in_sof;
    logic              in_eol;
    logic [DW-1:0]     mCCD_R;
    logic [DW-1:0]     mCCD_G;
    logic [DW-1:0]     mCCD_B;
    logic [9*DW-1:0]   win;
    logic              win_valid;
    logic [10:0]       cx;
    logic [9:0]        cy;
    logic              line_err;

    modport master (
        output in_valid, in_sof, in_eol, mCCD_R, mCCD_G, mCCD_B,
        input  win, win_valid, cx, cy, line_err
    );

    modport slave (
        input  in_valid, in_sof, in_eol, mCCD_R, mCCD_G, mCCD_B,
        output win, win_valid, cx, cy, line_err
    );
endinterface

// File: rtl/sobel_window_3x3.sv
// RGB-to-luma conversion plus two line buffers that assemble a 3x3 luma
// neighbourhood, its centre coordinates and a valid strobe for the Sobel stage.
module sobel_window_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int DW        = 10
) (
    input logic               clk,
    input logic               rst_n,
    sobel_window_3x3_if.slave bus
);
    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [10:0] LAST_COL = 11'(IMG_WIDTH - 1);
    localparam logic [9:0]  ROW_MAX  = 10'd1023;

    // Y = (R + 2G + B) >> 2; the sum cannot exceed DW+2 bits, so truncation is exact.
    function automatic logic [DW-1:0] f_luma(input logic [DW-1:0] r, g, b);
        logic [DW+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[DW+1:2];
    endfunction

    logic [10:0]        r_col;
    logic [9:0]         r_row;
    logic               r_line_err;

    logic               r_vld_p1;
    logic [10:0]        r_col_p1;
    logic [9:0]         r_row_p1;
    logic [DW-1:0]      r_y_p1;
    logic [DW-1:0]      r_lb1_rd_p1;
    logic [DW-1:0]      r_lb2_rd_p1;

    logic [8:0][DW-1:0] r_win_p2;
    logic               r_vld_p2;
    logic [10:0]        r_cx_p2;
    logic [9:0]         r_cy_p2;

    logic [DW-1:0]      r_lb1 [IMG_WIDTH];
    logic [DW-1:0]      r_lb2 [IMG_WIDTH];

    logic               w_acc;
    logic [10:0]        w_col;
    logic [9:0]         w_row;
    logic               w_last;
    logic               w_len_bad;
    logic               w_win_ok;

    always_comb begin
        w_acc     = bus.in_valid;
        w_col     = bus.in_sof ? 11'd0 : r_col;
        w_row     = bus.in_sof ? 10'd0 : r_row;
        w_last    = (w_col == LAST_COL);
        w_len_bad = (bus.in_eol != w_last);
        w_win_ok  = r_vld_p1 && (r_row_p1 >= 10'd2) && (r_col_p1 >= 11'd2);
    end

    // ---- stage 1: position counters, line-length check, luma and RAM reads ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_line_err <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_col_p1   <= '0;
            r_row_p1   <= '0;
        end else begin
            r_vld_p1 <= w_acc;
            if (w_acc) begin
                r_col_p1   <= w_col;
                r_row_p1   <= w_row;
                r_line_err <= (r_line_err & ~bus.in_sof) | w_len_bad;
                if (w_last) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_MAX) ? w_row : w_row + 10'd1;
                end else begin
                    r_col <= w_col + 11'd1;
                    r_row <= w_row;
                end
            end
        end
    end

    // Write-back of the previous pixel uses the lb1 value read a cycle earlier,
    // so each column shifts row-1 into the row-2 buffer before being overwritten.
    always_ff @(posedge clk) begin
        if (r_vld_p1) begin
            r_lb1[r_col_p1[AW-1:0]] <= r_y_p1;
            r_lb2[r_col_p1[AW-1:0]] <= r_lb1_rd_p1;
        end
        if (w_acc) begin
            r_y_p1      <= f_luma(bus.mCCD_R, bus.mCCD_G, bus.mCCD_B);
            r_lb1_rd_p1 <= r_lb1[w_col[AW-1:0]];
            r_lb2_rd_p1 <= r_lb2[w_col[AW-1:0]];
        end
    end

    // ---- stage 2: window shift and centre coordinates ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_p2 <= '0;
            r_vld_p2 <= 1'b0;
            r_cx_p2  <= '0;
            r_cy_p2  <= '0;
        end else begin
            r_vld_p2 <= w_win_ok;
            if (r_vld_p1) begin
                r_win_p2 <= {r_y_p1,      r_win_p2[8:7],
                             r_lb1_rd_p1, r_win_p2[5:4],
                             r_lb2_rd_p1, r_win_p2[2:1]};
            end
            if (w_win_ok) begin
                r_cx_p2 <= r_col_p1 - 11'd1;
                r_cy_p2 <= r_row_p1 - 10'd1;
            end
        end
    end

    assign bus.win       = r_win_p2;
    assign bus.win_valid = r_vld_p2;
    assign bus.cx        = r_cx_p2;
    assign bus.cy        = r_cy_p2;
    assign bus.line_err  = r_line_err;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Scoreboard bench for sobel_window_3x3: a frame-image model predicts every
// valid window, which is compared when the DUT raises win_valid.
module tb_sobel_window_3x3;
    localparam int W  = 8;
    localparam int DW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sobel_window_3x3_if #(.DW(DW)) bus();

    sobel_window_3x3 #(.IMG_WIDTH(W), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [9*DW-1:0] win;
        logic [10:0]     cx;
        logic [9:0]      cy;
        int              cyc;
    } exp_t;

    exp_t            q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc   = 0;
    int              n_win = 0;
    int              w0;
    int              m_row = 0;
    int              m_col = 0;
    logic [DW-1:0]   img [0:15][0:W-1];
    logic [9*DW-1:0] first_win = '0;
    bit              first_set = 1'b0;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.win_valid) begin
            n_win++;
            if (!first_set && bus.cx == 11'd1 && bus.cy == 10'd1) begin
                first_win = bus.win;
                first_set = 1'b1;
            end
            if (q.size() == 0) begin
                chk_eq("unexpected_valid", 128'(bus.win_valid), 128'(0));
            end else begin
                e = q.pop_front();
                chk_eq("win", 128'(bus.win), 128'(e.win));
                chk_eq("cx", 128'(bus.cx), 128'(e.cx));
                chk_eq("cy", 128'(bus.cy), 128'(e.cy));
                chk_eq("latency", 128'(cyc), 128'(e.cyc + 2));
            end
        end
    end

    task automatic px(input logic sof, input logic eol,
                      input logic [DW-1:0] ir, input logic [DW-1:0] ig, input logic [DW-1:0] ib);
        logic [DW-1:0] y;
        exp_t          e;
        y = DW'((int'(ir) + 2 * int'(ig) + int'(ib)) >> 2);
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = y;
        if (m_row >= 2 && m_col >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(i*3+j)*DW +: DW] = img[m_row-2+i][m_col-2+j];
            e.cx  = 11'(m_col - 1);
            e.cy  = 10'(m_row - 1);
            e.cyc = cyc;
            q.push_back(e);
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row++;
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_eol   = eol;
        bus.mCCD_R   = ir;
        bus.mCCD_G   = ig;
        bus.mCCD_B   = ib;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int rows, input bit stall, input bit rnd, input bit sof, input int limit);
        int            k;
        logic [DW-1:0] a, b, d;
        k = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (k < limit) begin
                    if (rnd) begin
                        a = DW'($urandom_range(0, 1023));
                        b = DW'($urandom_range(0, 1023));
                        d = DW'($urandom_range(0, 1023));
                    end else begin
                        a = DW'(16 * r + c);
                        b = a;
                        d = a;
                    end
                    px(sof && r == 0 && c == 0, c == W - 1, a, b, d);
                    if (stall) idle(1);
                    k++;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
        bus.mCCD_R   = '0;
        bus.mCCD_G   = '0;
        bus.mCCD_B   = '0;
        #1 rst_n = 1'b0;
        #11;
        chk_eq("rst_win", 128'(bus.win), 128'(0));
        chk_eq("rst_win_valid", 128'(bus.win_valid), 128'(0));
        chk_eq("rst_cx", 128'(bus.cx), 128'(0));
        chk_eq("rst_cy", 128'(bus.cy), 128'(0));
        chk_eq("rst_line_err", 128'(bus.line_err), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // luma corner cases observed on p8 two edges after acceptance
        px(1'b1, 1'b0, 10'd1023, 10'd1023, 10'd1023);
        idle(1);
        chk_eq("luma_max", 128'(bus.win[9*DW-1:8*DW]), 128'(1023));
        px(1'b0, 1'b0, 10'd4, 10'd0, 10'd0);
        idle(1);
        chk_eq("luma_r4", 128'(bus.win[9*DW-1:8*DW]), 128'(1));
        px(1'b0, 1'b0, 10'd0, 10'd2, 10'd0);
        idle(1);
        chk_eq("luma_g2", 128'(bus.win[9*DW-1:8*DW]), 128'(1));

        // ramp frame, continuous
        w0 = n_win;
        frame(4, 1'b0, 1'b0, 1'b1, 1000);
        idle(3);
        chk_eq("ramp_count", 128'(n_win - w0), 128'(12));
        chk_eq("ramp_first_p0", 128'(first_win[DW-1:0]), 128'(0));
        chk_eq("ramp_first_p4", 128'(first_win[5*DW-1:4*DW]), 128'(17));
        chk_eq("ramp_first_p8", 128'(first_win[9*DW-1:8*DW]), 128'(34));
        chk_eq("ramp_line_err", 128'(bus.line_err), 128'(0));

        // same ramp with a gap after every pixel
        w0 = n_win;
        frame(4, 1'b1, 1'b0, 1'b1, 1000);
        idle(3);
        chk_eq("stall_count", 128'(n_win - w0), 128'(12));

        // random colour frame
        w0 = n_win;
        frame(4, 1'b0, 1'b1, 1'b1, 1000);
        idle(3);
        chk_eq("rand_count", 128'(n_win - w0), 128'(12));

        // short line: eol on col 5
        for (int c = 0; c < W; c++) px(c == 0, c == 5, 10'd5, 10'd5, 10'd5);
        idle(1);
        chk_eq("short_err_set", 128'(bus.line_err), 128'(1));
        idle(4);
        chk_eq("short_err_sticky", 128'(bus.line_err), 128'(1));
        px(1'b1, 1'b0, 10'd7, 10'd7, 10'd7);
        idle(1);
        chk_eq("short_err_clr", 128'(bus.line_err), 128'(0));

        // mid-frame restart: sof lands where (2,4) would be
        w0 = n_win;
        frame(4, 1'b0, 1'b0, 1'b1, 2 * W + 4);
        frame(4, 1'b0, 1'b1, 1'b1, 1000);
        idle(3);
        chk_eq("restart_count", 128'(n_win - w0), 128'(14));

        // asynchronous reset in the middle of row 3
        frame(4, 1'b0, 1'b0, 1'b1, 3 * W + 4);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("arst_win_valid", 128'(bus.win_valid), 128'(0));
        chk_eq("arst_win", 128'(bus.win), 128'(0));
        chk_eq("arst_cx", 128'(bus.cx), 128'(0));
        chk_eq("arst_cy", 128'(bus.cy), 128'(0));
        q.delete();
        m_row = 0;
        m_col = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        w0 = n_win;
        frame(4, 1'b0, 1'b0, 1'b0, 1000);
        idle(3);
        chk_eq("post_rst_count", 128'(n_win - w0), 128'(12));
        chk_eq("post_rst_line_err", 128'(bus.line_err), 128'(0));
        chk_eq("queue_drained", 128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
